obi_to_wb: RTL

OBI-to-Wishbone bridge: an OBI responder that accepts one request at a time from an OBI initiator (core instruction or data port) and replays it as a Wishbone classic master cycle toward Wishbone peripherals. The Wishbone slave response (ack/err) is returned as an OBI response phase (`rvalid_o`/`err_o`). A watchdog aborts Wishbone cycles that never terminate, so a missing peripheral cannot hang the core.

---
 rtl/obi_wb_pkg.sv | 21 ++
 rtl/bus_watchdog.sv | 44 ++++
 rtl/obi_to_wb.sv | 114 +++++++++++
 3 files changed

// File: rtl/obi_wb_pkg.sv
// Shared types and constants for the OBI-to-Wishbone bridge and its bus watchdog.
package obi_wb_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = OBI_DATA_W / 8;

    localparam logic [OBI_DATA_W-1:0] OBI_ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WB_CYCLE = 2'd1,
        RESP     = 2'd2
    } obi_wb_state_t;

    // Counter width able to hold max_count itself; never narrower than one bit.
    function automatic int wd_count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter that flags when a bus cycle has run MAX_COUNT cycles.
// MAX_COUNT = 0 turns the whole counter into constant zero.
module bus_watchdog
    import obi_wb_pkg::*;
#(
    parameter int MAX_COUNT = 255,
    parameter int CNT_W     = wd_count_width(MAX_COUNT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic             expired_o,
    output logic [CNT_W-1:0] count_o
);

    generate
        if (MAX_COUNT == 0) begin : g_off
            logic w_unused_inputs;
            assign w_unused_inputs = ^{clk_i, rst_i, clr_i, en_i};
            assign count_o         = '0;
            assign expired_o       = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_COUNT);
            localparam logic [CNT_W-1:0] SAT   = {CNT_W{1'b1}};

            logic [CNT_W-1:0] r_count;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_count <= '0;
                end else if (clr_i) begin
                    r_count <= '0;
                end else if (en_i && (r_count != SAT)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign count_o   = r_count;
            assign expired_o = (r_count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/obi_to_wb.sv
// OBI responder that replays each accepted request as one Wishbone classic cycle,
// returning ack/err (or a watchdog abort) as a single-cycle OBI response.
module obi_to_wb
    import obi_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [OBI_ADDR_W-1:0] addr_i,
    input  logic                  we_i,
    input  logic [OBI_BE_W-1:0]   be_i,
    input  logic [OBI_DATA_W-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [OBI_DATA_W-1:0] rdata_o,
    output logic                  err_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [OBI_BE_W-1:0]   wbm_sel_o,
    output logic [OBI_ADDR_W-1:0] wbm_adr_o,
    output logic [OBI_DATA_W-1:0] wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic [OBI_DATA_W-1:0] wbm_dat_i
);

    localparam int WD_W = wd_count_width(TIMEOUT_CYCLES);

    obi_wb_state_t         r_state;
    logic                  r_we;
    logic [OBI_BE_W-1:0]   r_sel;
    logic [OBI_ADDR_W-1:0] r_adr;
    logic [OBI_DATA_W-1:0] r_dat;
    logic [OBI_DATA_W-1:0] r_rdata;
    logic                  r_err;

    logic                  w_in_cycle;
    logic                  w_accept;
    logic                  w_expired;
    logic [WD_W-1:0]       w_wd_count_unused;

    assign w_in_cycle = (r_state == WB_CYCLE);
    assign gnt_o      = !w_in_cycle;
    assign w_accept   = req_i && gnt_o;

    bus_watchdog #(
        .MAX_COUNT (TIMEOUT_CYCLES),
        .CNT_W     (WD_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (wb_rst_i),
        .clr_i     (w_accept),
        .en_i      (w_in_cycle),
        .expired_o (w_expired),
        .count_o   (w_wd_count_unused)
    );

    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                WB_CYCLE: begin
                    // err outranks ack, and a real ack outranks the watchdog
                    if (wbm_err_i) begin
                        r_state <= RESP;
                        r_err   <= 1'b1;
                        r_rdata <= OBI_ERR_RDATA;
                    end else if (wbm_ack_i) begin
                        r_state <= RESP;
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? '0 : wbm_dat_i;
                    end else if (w_expired) begin
                        r_state <= RESP;
                        r_err   <= 1'b1;
                        r_rdata <= OBI_ERR_RDATA;
                    end
                end
                default: begin
                    // IDLE and RESP both grant, so a new request may follow a response directly
                    if (w_accept) begin
                        r_state <= WB_CYCLE;
                        r_we    <= we_i;
                        r_sel   <= be_i;
                        r_adr   <= addr_i;
                        r_dat   <= wdata_i;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rvalid_o  = (r_state == RESP);
    assign rdata_o   = r_rdata;
    assign err_o     = r_err;
    assign wbm_cyc_o = w_in_cycle;
    assign wbm_stb_o = w_in_cycle;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;

endmodule
